// File: rtl/st7920_pkg.sv
// Shared types, constants and the frame builder for the ST7920 3-wire serial link.
// Both the sequencer and the serial transmitter import this package.
package st7920_pkg;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT
  } st7920_state_e;

  localparam logic [4:0] SYNC         = 5'b11111;
  localparam logic [7:0] CLEAR_OPCODE = 8'h01;
  localparam int         FRAME_BITS   = 24;

  typedef logic [FRAME_BITS-1:0] st7920_frame_t;

  // Sync, RW=0, RS, 0, then each data nibble followed by four zero bits.
  function automatic st7920_frame_t st7920_frame(input logic rs, input logic [7:0] data);
    return {SYNC, 1'b0, rs, 1'b0, data[7:4], 4'b0000, data[3:0], 4'b0000};
  endfunction

  // Display Clear needs the long execution time.
  function automatic logic st7920_is_clear(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data == CLEAR_OPCODE);
  endfunction

endpackage

// File: rtl/st7920_serial_tx_if.sv
// Command handshake between the LCD sequencer (master) and the serial transmitter (slave).
interface st7920_serial_tx_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/st7920_bit_timer.sv
// SCLK prescaler: emits a one-cycle phase_tick every CLK_DIV enabled cycles and
// toggles the SCLK level on each tick. Cleared at frame start and on reset.
module st7920_bit_timer #(
  parameter int CLK_DIV = 512
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic phase_tick_o,
  output logic sclk_o
);

  localparam int              DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;

  assign phase_tick_o = enable_i && !clear_i && (div_q == DIV_LAST);
  assign sclk_o       = sclk_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    div_d  = div_q;
    sclk_d = sclk_q;
    if (clear_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (enable_i) begin
      if (phase_tick_o) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (sys_rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/st7920_serial_tx.sv
// ST7920 3-wire serial transmitter: accepts one command per handshake, shifts the
// 24-bit frame out on CS/SCLK/SID, then holds off for the command's execution time.
module st7920_serial_tx
  import st7920_pkg::*;
#(
  parameter int CLK_DIV    = 512,
  parameter int CMD_WAIT   = 1944,
  parameter int CLR_WAIT   = 43200,
  parameter int PWRUP_WAIT = 1080000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  st7920_serial_tx_if.slave    cmd,
  output logic                 busy,
  output logic                 lcd_cs,
  output logic                 lcd_sclk,
  output logic                 lcd_sid
);

  localparam int MAX_AB   = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
  localparam int MAX_WAIT = (MAX_AB > PWRUP_WAIT) ? MAX_AB : PWRUP_WAIT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;
  localparam int BW       = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_WAIT - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_WAIT - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(FRAME_BITS - 1);

  st7920_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  st7920_frame_t frame_q, frame_d;
  logic          clr_sel_q, clr_sel_d;

  logic          accept;
  logic          phase_tick;
  logic          sclk_level;
  logic [CW-1:0] wait_last;

  assign accept    = (state_q == ST_IDLE) && cmd.cmd_valid;
  assign wait_last = clr_sel_q ? CLR_LAST : CMD_LAST;

  st7920_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .clear_i      (accept),
    .enable_i     (state_q == ST_SHIFT),
    .phase_tick_o (phase_tick),
    .sclk_o       (sclk_level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    clr_sel_d = clr_sel_q;
    unique case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d   = ST_SHIFT;
          frame_d   = st7920_frame(cmd.cmd_rs, cmd.cmd_data);
          clr_sel_d = st7920_is_clear(cmd.cmd_rs, cmd.cmd_data);
          bit_d     = BIT_FIRST;
        end
      end
      ST_SHIFT: begin
        // A tick while SCLK is high ends the bit; SID advances on that falling edge.
        if (phase_tick && sclk_level) begin
          if (bit_q == '0) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_PWRUP;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      clr_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      clr_sel_q <= clr_sel_d;
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign lcd_cs        = (state_q == ST_SHIFT);
  assign lcd_sclk      = lcd_cs && sclk_level;
  assign lcd_sid       = lcd_cs && frame_q[bit_q];

endmodule

// File: tb/tb_st7920_serial_tx.sv
// Self-checking bench for st7920_serial_tx: table of single commands, a queued burst,
// and a mid-frame reset, with a negedge monitor that reassembles frames from SID.
module tb_st7920_serial_tx;

  localparam int CLK_DIV    = 2;
  localparam int CMD_WAIT   = 10;
  localparam int CLR_WAIT   = 40;
  localparam int PWRUP_WAIT = 20;
  localparam int CMD_GAP    = 1 + 48 * CLK_DIV + CMD_WAIT;
  localparam int CLR_GAP    = 1 + 48 * CLK_DIV + CLR_WAIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, lcd_cs, lcd_sclk, lcd_sid;

  st7920_serial_tx_if cmd ();

  st7920_serial_tx #(
    .CLK_DIV    (CLK_DIV),
    .CMD_WAIT   (CMD_WAIT),
    .CLR_WAIT   (CLR_WAIT),
    .PWRUP_WAIT (PWRUP_WAIT)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .cmd      (cmd),
    .busy     (busy),
    .lcd_cs   (lcd_cs),
    .lcd_sclk (lcd_sclk),
    .lcd_sid  (lcd_sid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame monitor: samples SID on each SCLK rise inside CS, records the frame when CS drops.
  logic        prev_cs = 1'b0, prev_sclk = 1'b0, prev_sid = 1'b0;
  logic [23:0] acc = '0, last_frame = '0;
  int          nbits = 0, cs_len = 0, first_rise = -1;
  int          last_nbits = 0, last_cs_len = 0, last_first_rise = 0, frames_done = 0;

  always @(negedge clk) begin
    check("busy_vs_ready", busy, !cmd.cmd_ready);
    if (prev_sclk && lcd_sclk) check("sid_stable_sclk_high", lcd_sid, prev_sid);
    if (lcd_cs && !prev_cs) begin
      acc        <= '0;
      nbits      <= 0;
      cs_len     <= 1;
      first_rise <= -1;
    end else if (lcd_cs) begin
      cs_len <= cs_len + 1;
      if (lcd_sclk && !prev_sclk) begin
        acc   <= {acc[22:0], lcd_sid};
        nbits <= nbits + 1;
        if (first_rise < 0) first_rise <= cyc;
      end
    end
    if (!lcd_cs && prev_cs) begin
      last_frame      <= acc;
      last_nbits      <= nbits;
      last_cs_len     <= cs_len;
      last_first_rise <= first_rise;
      frames_done     <= frames_done + 1;
    end
    prev_cs   <= lcd_cs;
    prev_sclk <= lcd_sclk;
    prev_sid  <= lcd_sid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        rs;
    logic [7:0]  data;
    logic [23:0] frame;
    int          gap;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, output int r);
    for (int i = 0; i < 1000 && !cmd.cmd_ready; i++) tick();
    check({name, "_ready_seen"}, cmd.cmd_ready, 1'b1);
    r = cyc;
  endtask

  task automatic accept(input string name, input logic rs, input logic [7:0] d,
                        input logic [23:0] exp, output int t, output int f0);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_rs    = rs;
    cmd.cmd_data  = d;
    f0 = frames_done;
    @(posedge clk);
    #1;
    t = cyc;
    check({name, "_ready_low"}, cmd.cmd_ready, 1'b0);
    check({name, "_cs_high"},   lcd_cs,        1'b1);
    check({name, "_sclk_low"},  lcd_sclk,      1'b0);
    check({name, "_sid_msb"},   lcd_sid,       exp[23]);
  endtask

  task automatic complete(input string name, input int t, input int f0,
                          input logic [23:0] exp, input int gap);
    int r;
    wait_ready(name, r);
    check({name, "_gap"},        r + 1 - t,            gap);
    check({name, "_frames"},     frames_done - f0,     1);
    check({name, "_frame"},      last_frame,           exp);
    check({name, "_nbits"},      last_nbits,           24);
    check({name, "_cs_len"},     last_cs_len,          48 * CLK_DIV);
    check({name, "_first_rise"}, last_first_rise - t,  CLK_DIV);
  endtask

  initial begin
    int t, f0, t0, t1, t2, r, c, act;

    vecs[0] = '{"d41_data",   1'b1, 8'h41, 24'hFA4010, CMD_GAP};
    vecs[1] = '{"clear",      1'b0, 8'h01, 24'hF80010, CLR_GAP};
    vecs[2] = '{"d01_data",   1'b1, 8'h01, 24'hFA0010, CMD_GAP};
    vecs[3] = '{"i02_home",   1'b0, 8'h02, 24'hF80020, CMD_GAP};
    vecs[4] = '{"i81_addr",   1'b0, 8'h81, 24'hF88010, CMD_GAP};
    vecs[5] = '{"i30_func",   1'b0, 8'h30, 24'hF83000, CMD_GAP};

    // Reset with valid already held: nothing may be accepted or driven during power-up.
    cmd.cmd_valid = 1'b1;
    cmd.cmd_rs    = 1'b1;
    cmd.cmd_data  = 8'h41;
    repeat (3) tick();
    check("rst_ready", cmd.cmd_ready, 1'b0);
    check("rst_busy",  busy,          1'b1);
    check("rst_pins",  {lcd_cs, lcd_sclk, lcd_sid}, 3'b000);
    rst = 1'b0;
    c   = cyc;
    act = 0;
    for (int i = 0; i < 1000 && !cmd.cmd_ready; i++) begin
      act = act | int'(lcd_cs | lcd_sclk | lcd_sid);
      tick();
    end
    r = cyc;
    check("pwrup_len",      r - c, PWRUP_WAIT);
    check("pwrup_activity", act,   0);

    for (int i = 0; i < 6; i++) begin
      wait_ready(vecs[i].name, r);
      accept(vecs[i].name, vecs[i].rs, vecs[i].data, vecs[i].frame, t, f0);
      cmd.cmd_valid = 1'b0;
      cmd.cmd_rs    = ~vecs[i].rs;
      cmd.cmd_data  = ~vecs[i].data;
      complete(vecs[i].name, t, f0, vecs[i].frame, vecs[i].gap);
    end

    // Valid held across three commands; data is scrambled while busy.
    accept("q0", 1'b0, 8'h30, 24'hF83000, t0, f0);
    cmd.cmd_rs = 1'b1; cmd.cmd_data = 8'hA5;
    complete("q0", t0, f0, 24'hF83000, CMD_GAP);
    accept("q1", 1'b0, 8'h0C, 24'hF800C0, t1, f0);
    cmd.cmd_rs = 1'b1; cmd.cmd_data = 8'h5A;
    complete("q1", t1, f0, 24'hF800C0, CMD_GAP);
    accept("q2", 1'b0, 8'h01, 24'hF80010, t2, f0);
    cmd.cmd_valid = 1'b0;
    cmd.cmd_data  = 8'hFF;
    complete("q2", t2, f0, 24'hF80010, CLR_GAP);
    check("q_spacing01", t1 - t0, CMD_GAP);
    check("q_spacing12", t2 - t1, CMD_GAP);

    // Reset asserted during bit 10: pins drop without a clock edge, power-up repeats.
    accept("abort", 1'b1, 8'h41, 24'hFA4010, t, f0);
    repeat (54) tick();
    check("abort_cs_before", lcd_cs, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("abort_pins",  {lcd_cs, lcd_sclk, lcd_sid}, 3'b000);
    check("abort_ready", cmd.cmd_ready, 1'b0);
    check("abort_busy",  busy,          1'b1);
    repeat (3) tick();
    rst = 1'b0;
    c   = cyc;
    act = 0;
    for (int i = 0; i < 1000 && !cmd.cmd_ready; i++) begin
      act = act | int'(lcd_cs | lcd_sclk | lcd_sid);
      tick();
    end
    r = cyc;
    check("abort_pwrup_len",      r - c, PWRUP_WAIT);
    check("abort_pwrup_activity", act,   0);
    accept("after_abort", 1'b1, 8'h41, 24'hFA4010, t, f0);
    cmd.cmd_valid = 1'b0;
    complete("after_abort", t, f0, 24'hFA4010, CMD_GAP);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st7920_serial_tx.md
# st7920_serial_tx

Serial physical-layer transmitter for the ST7920 LCD controller in 3-wire serial mode. It sits directly downstream of the command/text sequencer. It accepts one 10-bit command per valid/ready handshake: RS, RW (forced to write), and 8 data bits. It serialises the command as the 24-bit ST7920 frame on CS/SCLK/SID, then enforces the controller's execution time before accepting the next command. This replaces the sequencer's fixed free-running delay counter with a true handshake and per-command wait times.

## Interface
Parameters:
- CLK_DIV, 512: sys_clk cycles per SCLK half-period; must be at least 1.
- CMD_WAIT, 1944: sys_clk cycles of idle after a normal command (72 us at 27 MHz).
- CLR_WAIT, 43200: sys_clk cycles of idle after Display Clear (1.6 ms at 27 MHz).
- PWRUP_WAIT, 1080000: sys_clk cycles after reset release before the first command is accepted (40 ms).

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_rs  in  1  0 = instruction, 1 = data.
- cmd_data  in  8  instruction or character byte.
- busy  out  1  equals !cmd_ready.
- lcd_cs  out  1  ST7920 CS (RS pin); high for the duration of a frame.
- lcd_sclk  out  1  ST7920 SCLK (E pin); idle low.
- lcd_sid  out  1  ST7920 SID (R/W pin); MSB first.

## Operation
- Frame, MSB first, 24 bits: 5'b11111, RW=0, RS, 1'b0, D7..D4, 4'b0000, D3..D0, 4'b0000.
- States:
  - PWRUP: entered on reset. cmd_ready=0. Counts PWRUP_WAIT cycles, then goes to IDLE.
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch the frame and the wait selection, then go to SHIFT.
  - SHIFT: shift out bits 23..0. Each bit is held with SCLK low for CLK_DIV cycles, then SCLK high for CLK_DIV cycles. SID changes only while SCLK is low (at a falling edge or at frame start); the LCD samples on the rising edge. After the high phase of bit 0, go to WAIT.
  - WAIT: CS, SCLK and SID are all 0. Counts the latched wait, then goes to IDLE.
- Wait selection: CLR_WAIT applies when cmd_rs==0 and cmd_data==8'h01; every other command uses CMD_WAIT. The selection is decided from the values at acceptance.
- Input changes while not ready are ignored; the frame is latched at the handshake.
- cmd_valid during PWRUP, SHIFT or WAIT is never accepted and never lost; the upstream block simply holds it.
- Counters are unsigned and sized with $clog2 of the largest parameter plus 1. There is no wrap-around, because each counter is reloaded at every state entry.

## Timing
- Reset values, asynchronous and immediate, including when reset is asserted mid-frame:
  - Outputs: cmd_ready=0, busy=1, lcd_cs=0, lcd_sclk=0, lcd_sid=0.
  - Internals: state=PWRUP, all counters 0.
- cmd_ready rises on the PWRUP_WAIT-th rising edge after sys_rst deasserts.
- Handshake accepted at edge T:
  - From T+1: cmd_ready=0, lcd_cs=1, lcd_sid=frame[23], lcd_sclk=0.
  - The first SCLK rising edge occurs at T+1+CLK_DIV.
  - At T+1+48*CLK_DIV: lcd_cs=0, lcd_sclk=0, lcd_sid=0.
  - cmd_ready=1 again at T+1+48*CLK_DIV+WAIT.
- Throughput: one command per 1+48*CLK_DIV+WAIT cycles. Back-to-back acceptance is possible on the first cycle cmd_ready is high.
- A frame aborted by reset is dropped. After release, the full PWRUP wait repeats.

## Structure
- st7920_pkg holds:
  - the state enum;
  - SYNC constant 5'b11111;
  - CLEAR_OPCODE 8'h01;
  - FRAME_BITS = 24;
  - function st7920_frame(rs, data) returning the 24-bit frame.
- The sequencer must also import st7920_pkg, rather than building frames itself.
- One sub-module, st7920_bit_timer: a CLK_DIV prescaler emitting a one-cycle phase_tick and tracking the SCLK level. It is cleared on frame start and on reset.

## Test plan
Bench parameters: CLK_DIV=2, CMD_WAIT=10, CLR_WAIT=40, PWRUP_WAIT=20.
- Release reset with cmd_valid=1 held -> cmd_ready rises exactly 20 edges later; no SCLK activity before then; CS/SCLK/SID stay 0 during PWRUP.
- Send rs=1, data=0x41 -> SID sampled on 24 SCLK rising edges reads 1111_1010_0100_0000_0001_0000; CS high for exactly 96 cycles; cmd_ready returns at T+107.
- Send rs=0, data=0x01 -> cmd_ready returns at T+137. Send rs=1, data=0x01 -> cmd_ready returns at T+107 (CMD_WAIT applies).
- Hold valid for 3 queued commands (0x30, 0x0C, 0x01) and change cmd_data while busy -> exactly 3 frames go out, each with the data present at its own acceptance; spacing is 107, 107, then 137 cycles after the last.
- Assert sys_rst during bit 10 -> CS/SCLK/SID and cmd_ready go 0 with no clock edge needed; after release, 20 cycles of PWRUP, then the next frame is complete and correct.
- Check throughout -> SID never changes while SCLK is high; busy == !cmd_ready on every cycle.
